// File: rtl/stc_pkg.sv
// Shared definitions for the stochastic-rounding noise generator: LFSR constants,
// FSM state type and the multi-step LFSR helper used by every lane.
package stc_pkg;

    localparam int LFSR_W = 32;
    localparam logic [LFSR_W-1:0] LFSR_POLY = 32'h80200003;
    localparam logic [LFSR_W-1:0] LANE_SALT = 32'h9E3779B9;

    typedef enum logic [0:0] {
        WARMUP,
        RUN
    } stc_state_e;

    // Galois right-shift LFSR advanced n times; loop bound is fixed so it unrolls for any n <= 32.
    function automatic logic [LFSR_W-1:0] lfsr_step_n(input logic [LFSR_W-1:0] state, input int n);
        logic [LFSR_W-1:0] s;
        s = state;
        for (int i = 0; i < LFSR_W; i++) begin
            if (i < n) s = (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
        end
        return s;
    endfunction

    function automatic logic [LFSR_W-1:0] lane_seed(input logic [LFSR_W-1:0] seed, input int k);
        logic [LFSR_W-1:0] s;
        s = seed ^ (LFSR_W'(k) * LANE_SALT);
        return (s == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : s;
    endfunction

endpackage

// File: rtl/stc_lfsr_lane.sv
// One noise lane: 32-bit Galois LFSR with synchronous seed load and gated
// width_n-step advance (or two batches on the final warm-up cycle).
module stc_lfsr_lane
    import stc_pkg::*;
#(
    parameter int width_n  = 6,
    parameter int lane_idx = 0
) (
    input  logic               clk,
    input  logic               load,
    input  logic [LFSR_W-1:0]  seed,
    input  logic               adv,
    input  logic               dbl,
    output logic [width_n-1:0] word
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] step1;
    logic [LFSR_W-1:0] step2;
    logic [LFSR_W-1:0] next_state;

    assign step1      = lfsr_step_n(state_q, width_n);
    assign step2      = lfsr_step_n(step1, width_n);
    assign next_state = dbl ? step2 : step1;
    assign word       = next_state[width_n-1:0];

    always_ff @(posedge clk) begin
        if (load) begin
            state_q <= lane_seed(seed, lane_idx);
        end else if (adv) begin
            state_q <= next_state;
        end
    end

endmodule

// File: rtl/stc_noise_gen.sv
// Uniform noise producer for a bank of stochastic rounders: one LFSR lane per
// rounder, words delivered over a valid/ready handshake after a warm-up period.
//
//   state  | meaning
//   WARMUP | lanes free-run, output invalid, down-counter running to 1
//   RUN    | o_noise valid; lanes advance only when a word is accepted
module stc_noise_gen
    import stc_pkg::*;
#(
    parameter int          width_n  = 6,
    parameter int          lanes    = 4,
    parameter int          warmup   = 8,
    parameter logic [31:0] def_seed = 32'hACE12468
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_seed_vld,
    input  logic [31:0]                i_seed,
    input  logic                       i_ready,
    output logic                       o_valid,
    output logic [lanes*width_n-1:0]   o_noise,
    output logic                       o_busy
);

    localparam int NW = lanes * width_n;

    stc_state_e        state;
    logic [7:0]        warm_cnt;
    logic              load;
    logic              adv;
    logic              dbl;
    logic [LFSR_W-1:0] load_seed;
    logic [NW-1:0]     words;

    assign load      = i_rst | i_seed_vld;
    assign load_seed = i_rst ? def_seed : i_seed;
    // The last warm-up cycle also produces the first word, so lanes take two batches of steps.
    assign dbl       = (state == WARMUP) && (warm_cnt == 8'd1);
    assign adv       = (state == WARMUP) || ((state == RUN) && i_ready);

    for (genvar k = 0; k < lanes; k++) begin : g_lane
        stc_lfsr_lane #(
            .width_n  (width_n),
            .lane_idx (k)
        ) u_lane (
            .clk  (i_clk),
            .load (load),
            .seed (load_seed),
            .adv  (adv),
            .dbl  (dbl),
            .word (words[k*width_n +: width_n])
        );
    end

    always_ff @(posedge i_clk) begin
        if (load) begin
            state    <= WARMUP;
            warm_cnt <= 8'(warmup);
            o_valid  <= 1'b0;
            o_busy   <= 1'b1;
            o_noise  <= '0;
        end else begin
            case (state)
                WARMUP: begin
                    warm_cnt <= warm_cnt - 8'd1;
                    if (dbl) begin
                        state   <= RUN;
                        o_valid <= 1'b1;
                        o_busy  <= 1'b0;
                        o_noise <= words;
                    end
                end
                RUN: begin
                    if (i_ready) o_noise <= words;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stc_noise_gen.sv
// Scoreboard bench for stc_noise_gen: a plain LFSR reference model queues the
// expected accepted-word stream per seed; a negedge monitor checks each accepted word.
module tb_stc_noise_gen;

    localparam int          W     = 6;
    localparam int          LANES = 4;
    localparam int          WARM  = 8;
    localparam logic [31:0] DEF   = 32'hACE12468;
    localparam int          NW    = W * LANES;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_seed_vld = 1'b0;
    logic [31:0]   i_seed = '0;
    logic          i_ready = 1'b0;
    logic          o_valid;
    logic [NW-1:0] o_noise;
    logic          o_busy;

    int tests = 0;
    int fails = 0;

    logic [NW-1:0] sb_q[$];
    logic [NW-1:0] exp_w;

    bit stats_on = 1'b0;
    int hist [LANES][2**W];
    int run_eq = 0;
    int max_run = 0;

    stc_noise_gen #(
        .width_n  (W),
        .lanes    (LANES),
        .warmup   (WARM),
        .def_seed (DEF)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_seed_vld (i_seed_vld),
        .i_seed     (i_seed),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_noise    (o_noise),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    // Expected stream: first word after WARM*W + W steps, then W steps per accepted word.
    function automatic void model_load(input logic [31:0] seed, input int nw);
        logic [31:0]   st [LANES];
        logic [NW-1:0] w;
        for (int k = 0; k < LANES; k++) begin
            st[k] = seed ^ (32'(k) * 32'h9E3779B9);
            if (st[k] == 32'h0) st[k] = 32'h1;
            for (int i = 0; i < WARM * W; i++) st[k] = ref_step(st[k]);
        end
        for (int n = 0; n < nw; n++) begin
            for (int k = 0; k < LANES; k++) begin
                for (int i = 0; i < W; i++) st[k] = ref_step(st[k]);
                w[k*W +: W] = st[k][W-1:0];
            end
            sb_q.push_back(w);
        end
    endfunction

    always @(negedge clk) begin
        if (!i_rst && !i_seed_vld && o_valid && i_ready) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got %h expected none (queue empty)", o_noise);
            end else begin
                exp_w = sb_q.pop_front();
                chk("noise_word", 64'(o_noise), 64'(exp_w));
                if (stats_on) begin
                    for (int k = 0; k < LANES; k++) hist[k][o_noise[k*W +: W]]++;
                    if (o_noise[W-1:0] == o_noise[2*W-1:W]) run_eq++;
                    else run_eq = 0;
                    if (run_eq > max_run) max_run = run_eq;
                end
            end
        end
    end

    task automatic seed_phase(input bit rst, input bit sv, input logic [31:0] sd,
                              input logic [31:0] mseed, input int nw, input bit rdy);
        i_rst      = rst;
        i_seed_vld = sv;
        i_seed     = sd;
        i_ready    = rdy;
        @(posedge clk);
        #1;
        i_rst      = 1'b0;
        i_seed_vld = 1'b0;
        model_load(mseed, nw);
        @(negedge clk);
        chk("load_valid", 64'(o_valid), 64'd0);
        chk("load_busy", 64'(o_busy), 64'd1);
        chk("load_noise", 64'(o_noise), 64'd0);
        for (int e = 1; e <= WARM; e++) begin
            @(posedge clk);
            @(negedge clk);
            chk("warm_valid", 64'(o_valid), 64'(e == WARM));
            chk("warm_busy", 64'(o_busy), 64'(e != WARM));
        end
    endtask

    task automatic drain(input int budget, input bit rnd);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (rnd) i_ready = 1'($urandom_range(0, 1));
        end
        i_ready = 1'b0;
        if (sb_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d words left expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        int bad;
        repeat (2) @(posedge clk);
        #1;

        // Reset release, then stall after three accepted words.
        seed_phase(1'b1, 1'b0, 32'h0, DEF, 12, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_noise", 64'(o_noise), 64'(sb_q[0]));
            chk("stall_valid", 64'(o_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        drain(200, 1'b0);

        // Mid-RUN reseed with zero seed: lane 0 falls back to 1.
        seed_phase(1'b0, 1'b1, 32'h0, 32'h0, 20, 1'b1);
        drain(200, 1'b0);

        // Reset and reseed together: reset wins. Collect statistics here.
        for (int k = 0; k < LANES; k++)
            for (int v = 0; v < 2**W; v++) hist[k][v] = 0;
        run_eq   = 0;
        max_run  = 0;
        stats_on = 1'b1;
        seed_phase(1'b1, 1'b1, 32'h12345678, DEF, 4096, 1'b1);
        drain(5000, 1'b0);
        stats_on = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            bad = 0;
            for (int v = 0; v < 2**W; v++)
                if (hist[k][v] < 32 || hist[k][v] > 96) bad++;
            chk("hist_bins_out_of_range", 64'(bad), 64'd0);
        end
        chk("lane01_identical_run16", 64'(max_run >= 16), 64'd0);

        // Random seed with 50% ready: stream must still follow the model.
        seed_phase(1'b0, 1'b1, 32'hC0FFEE11 ^ $urandom, 32'h0, 0, 1'b1);
        sb_q.delete();
        begin
            logic [31:0] rs;
            rs = $urandom;
            seed_phase(1'b0, 1'b1, rs, rs, 3000, 1'b1);
        end
        drain(20000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stc_noise_gen.md
Name: stc_noise_gen

Overview:
- Producer side of the stochastic-rounding noise interface: generates the uniform pseudo-random noise words that rnd_stc instances consume on i_noise.
- One 32-bit Galois LFSR per lane, advanced width_n steps per delivered word; noise is presented through a valid/ready handshake.
- Sits beside a bank of rnd_stc units in the MX quantisation datapath; one lane feeds one rounder.

Parameters:
- width_n, 6, noise bits per lane (matches rnd_stc i_noise width); legal range 1..32.
- lanes, 4, number of independent noise lanes; legal range 1..16.
- warmup, 8, LFSR advance cycles discarded after reset/reseed before the first valid word; legal range 1..255.
- def_seed, 32'hACE12468, seed used out of reset.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_seed_vld  in  1  load i_seed this cycle (one-cycle pulse or level; sampled each edge).
- i_seed  in  32  new base seed.
- i_ready  in  1  consumer accepts o_noise this cycle.
- o_valid  out  1  o_noise holds a fresh word.
- o_noise  out  lanes*width_n  lane k occupies bits [k*width_n +: width_n].
- o_busy  out  1  high while in WARMUP.

Behaviour:
- Polynomial x^32+x^22+x^2+x+1, Galois form, right shift: next = (s>>1) ^ (s[0] ? 32'h80200003 : 0).
- Lane seed: seed ^ (k * 32'h9E3779B9) truncated to 32 bits; a lane seed of 0 is replaced by 32'h00000001. No lane state is ever all-zero.
- Step function: width_n serial LFSR steps unrolled combinationally per cycle. Lane word = low width_n bits of the state after those steps.
- States: WARMUP, RUN.
- Reset: state=WARMUP, lanes loaded from def_seed, counter=warmup, o_valid=0, o_noise=0, o_busy=1.
- WARMUP: each cycle, all lanes step and the counter decrements. On the cycle the counter equals 1:
  - lanes step again;
  - o_noise loads the new lane words;
  - o_valid=1, o_busy=0, state goes to RUN.
  - Net effect: o_valid is first high after exactly warmup rising edges with i_rst low.
- RUN, o_valid && i_ready: lanes step, o_noise updates, and o_valid stays 1. Throughput is one word per cycle.
- RUN, o_valid && !i_ready: lanes and o_noise hold bit-stable (no advance while stalled).
- i_seed_vld high in any state, i_rst low: on the next edge,
  - lanes load from i_seed and counter=warmup;
  - state=WARMUP, o_valid=0, o_busy=1, o_noise=0;
  - any unaccepted word is discarded.
- Priority: i_rst > i_seed_vld > handshake. i_ready is ignored while o_valid=0.
- Determinism: a given seed always yields the identical word sequence, regardless of stall pattern. The sequence depends only on the count of accepted words.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package stc_pkg:
  - LFSR_POLY=32'h80200003;
  - LANE_SALT=32'h9E3779B9;
  - LFSR_W=32;
  - state enum {WARMUP, RUN};
  - a function lfsr_step_n(state, n) reused by the bench's C/SV model.
- One sub-module, stc_lfsr_lane:
  - one lane state register with synchronous load (seed with zero-fix), enable-gated advance, width_n-step unrolling, and word output;
  - instantiated lanes times.
  - The top holds the FSM, warmup counter, and output register.

Test Plan:
- Reset release, i_ready=1: o_valid=0 and o_busy=1 for edges 1..7; o_valid=1 after edge 8. Lane 0 word equals the DPI model value for seed 32'hACE12468 after 8*6+6 steps; all lanes must match the model.
- Stall: after 3 accepted words hold i_ready=0 for 5 cycles. o_noise is constant for those 5 cycles. When i_ready returns to 1, words 4,5,... equal the model with no gap or skip.
- Reseed mid-RUN with i_seed=32'h00000000:
  - lane 0 seed becomes 32'h1, other lanes carry the salts;
  - o_valid=0 the next cycle, then o_valid high again after 8 edges;
  - outputs match the model, and no lane is ever all-zero.
- Simultaneous i_rst=1 and i_seed_vld=1 with i_seed=32'h12345678: the def_seed sequence results (reset wins).
- Statistics: 4096 accepted words per lane with i_ready=1. Each of the 64 values occurs 32..96 times per lane. Lanes 0 and 1 are never identical for 16 consecutive words.
- Random i_ready (50%) over 10000 cycles: the accepted-word stream is identical to the i_ready=1 stream. Feeding it to rnd_stc yields mean rounding error within ±2% of LSB/2 expectation.
